// File: rtl/dram_fifo_bist_gen.sv
// Settings-bus programmed CVITA packet generator that feeds test traffic into the DRAM FIFO path.
// Emits header + payload packets with optional inter-packet gap, counted or continuous runs.
module dram_fifo_bist_gen #(
  parameter int SR_BASE   = 0,
  parameter int SR_AWIDTH = 8
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  output logic [63:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 running,
  output logic                 done,
  output logic [31:0]          pkt_cnt
);

  // Output stream handshake: a word transfers on a rising edge where o_tvalid && o_tready;
  // o_tdata/o_tlast hold steady while o_tvalid is high and o_tready is low.

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [31:0] cfg_r, seed_r;
  logic [7:0]  gap_r;
  logic        run_ramp, run_cont;
  logic [17:0] run_num;
  logic [10:0] run_words;
  logic [7:0]  run_gap, gap_cnt;
  logic [31:0] run_seed;
  logic [10:0] word_idx;
  logic        stop_req;

  logic ctrl_wr, go_wr, stop_wr, start, hs, last_word, stop_now, end_run;
  logic [13:0] len_p7;
  logic [10:0] words_calc;
  logic [31:0] pkt_next;

  assign ctrl_wr   = set_stb && (set_addr == SR_AWIDTH'(SR_BASE));
  assign go_wr     = ctrl_wr && set_data[0];
  assign stop_wr   = ctrl_wr && !set_data[0];
  assign start     = go_wr && (state == S_IDLE || state == S_FINISH);
  assign hs        = o_tvalid && o_tready;
  assign last_word = (word_idx == run_words - 11'd1);
  assign stop_now  = stop_req || stop_wr;
  assign pkt_next  = pkt_cnt + 32'd1;
  assign end_run   = stop_now || (!run_cont && pkt_next == {14'd0, run_num});

  // ceil(len/8); a zero length still produces one payload word
  assign len_p7     = {1'b0, cfg_r[30:18]} + 14'd7;
  assign words_calc = (len_p7[13:3] == 11'd0) ? 11'd1 : len_p7[13:3];

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start)
          state_nxt = (cfg_r[17:0] == 18'd0 && !set_data[1]) ? S_FINISH : S_HDR;
        else if (state == S_FINISH && stop_wr)
          state_nxt = S_IDLE;
      end
      S_HDR:     if (hs) state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        if (hs && last_word) begin
          if (end_run)              state_nxt = S_FINISH;
          else if (run_gap != 8'd0) state_nxt = S_GAP;
          else                      state_nxt = S_HDR;
        end
      end
      S_GAP:     if (gap_cnt == 8'd0) state_nxt = stop_now ? S_FINISH : S_HDR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = (state == S_HDR) || (state == S_PAYLOAD);
    o_tlast  = (state == S_PAYLOAD) && last_word;
    running  = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_GAP);
    done     = (state == S_FINISH);
    o_tdata  = 64'd0;
    if (state == S_HDR)
      o_tdata = {4'b0000, pkt_cnt[11:0], {2'b00, run_words, 3'b000} + 16'd8, run_seed};
    else if (state == S_PAYLOAD)
      o_tdata = run_ramp ? {pkt_cnt, 21'd0, word_idx} : {run_seed, ~run_seed};
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      cfg_r     <= '0;
      gap_r     <= '0;
      seed_r    <= '0;
      run_ramp  <= 1'b0;
      run_cont  <= 1'b0;
      run_num   <= '0;
      run_words <= '0;
      run_gap   <= '0;
      run_seed  <= '0;
      gap_cnt   <= '0;
      word_idx  <= '0;
      pkt_cnt   <= '0;
      stop_req  <= 1'b0;
    end else begin
      if (set_stb && set_addr == SR_AWIDTH'(SR_BASE + 1)) cfg_r  <= set_data;
      if (set_stb && set_addr == SR_AWIDTH'(SR_BASE + 2)) gap_r  <= set_data[7:0];
      if (set_stb && set_addr == SR_AWIDTH'(SR_BASE + 3)) seed_r <= set_data;

      if (start)        stop_req <= 1'b0;
      else if (stop_wr) stop_req <= 1'b1;

      if (start) begin
        // snapshot so later register writes cannot disturb a run in progress
        run_ramp  <= cfg_r[31];
        run_cont  <= set_data[1];
        run_num   <= cfg_r[17:0];
        run_words <= words_calc;
        run_gap   <= gap_r;
        run_seed  <= seed_r;
        pkt_cnt   <= '0;
        word_idx  <= '0;
      end else if (state == S_PAYLOAD && hs) begin
        if (last_word) begin
          word_idx <= '0;
          pkt_cnt  <= pkt_next;
          gap_cnt  <= run_gap - 8'd1;
        end else begin
          word_idx <= word_idx + 11'd1;
        end
      end else if (state == S_GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dram_fifo_bist_gen.sv
// Randomized scoreboard bench for dram_fifo_bist_gen: a packet-level model fills the expected
// queue when a run is started, and a negedge monitor checks every transferred word.
module tb_dram_fifo_bist_gen;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [63:0] o_tdata;
  logic        o_tlast, o_tvalid;
  logic        o_tready = 1'b1;
  logic        running, done;
  logic [31:0] pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];

  logic rdy_rand = 1'b0;
  logic chk_gap  = 1'b0;
  int   exp_gap  = 0;

  dram_fifo_bist_gen #(.SR_BASE(0), .SR_AWIDTH(8)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .running(running), .done(done), .pkt_cnt(pkt_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 bus_clk = ~bus_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  always @(posedge bus_clk) begin
    #1;
    o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- model and driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_packets(input bit ramp, input int len, input int num, input logic [31:0] seed);
    int w;
    w = (len < 8) ? 1 : (len + 7) / 8;
    for (int p = 0; p < num; p++) begin
      logic [11:0] seq;
      logic [15:0] plen;
      seq  = 12'(p);
      plen = 16'(8 * w + 8);
      exp_q.push_back({1'b0, 4'b0000, seq, plen, seed});
      for (int k = 0; k < w; k++)
        exp_q.push_back({(k == w - 1), ramp ? {32'(p), 32'(k)} : {seed, ~seed}});
    end
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge bus_clk); #1;
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge bus_clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic configure(input bit ramp, input int len, input int num, input int gap,
                           input logic [31:0] seed);
    sr_write(8'd1, {ramp, 13'(len), 18'(num)});
    sr_write(8'd2, 32'(gap));
    sr_write(8'd3, seed);
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge bus_clk); #1;
      c++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: done not seen within %0d cycles (got 0 want 1)", name, budget);
    end
  endtask

  task automatic run_counted(input string name, input bit ramp, input int len, input int num,
                             input int gap, input logic [31:0] seed);
    int w;
    w = (len < 8) ? 1 : (len + 7) / 8;
    configure(ramp, len, num, gap, seed);
    push_packets(ramp, len, num, seed);
    sr_write(8'd0, 32'h1);
    wait_done(num * (w + 1 + gap) * 8 + 50, name);
    repeat (2) @(posedge bus_clk);
    #1;
    check({name, " pkt_cnt"}, 64'(pkt_cnt), 64'(num));
    check({name, " leftover"}, 64'(exp_q.size()), 64'd0);
    check({name, " running"}, 64'(running), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        stall_prev = 1'b0;
  logic [64:0] stall_word;
  logic        gap_arm = 1'b0, in_pkt = 1'b0;
  int          idle_cnt = 0;
  int          word_no = 0;

  always @(negedge bus_clk) begin
    if (!bus_rst_n) begin
      stall_prev = 1'b0; gap_arm = 1'b0; in_pkt = 1'b0;
    end else begin
      if (stall_prev && o_tvalid) begin
        n_cmp++;
        if ({o_tlast, o_tdata} !== stall_word) begin
          n_err++;
          $display("FAIL stable: got %h want %h", {o_tlast, o_tdata}, stall_word);
        end
      end
      stall_prev = o_tvalid && !o_tready;
      stall_word = {o_tlast, o_tdata};

      if (done) gap_arm = 1'b0;
      if (gap_arm && !o_tvalid) idle_cnt++;
      if (gap_arm && o_tvalid) begin
        gap_arm = 1'b0;
        if (chk_gap) begin
          n_cmp++;
          if (idle_cnt != exp_gap) begin
            n_err++;
            $display("FAIL gap: got %0d idle cycles want %0d", idle_cnt, exp_gap);
          end
        end
      end
      if (chk_gap && in_pkt && !o_tvalid) begin
        n_cmp++; n_err++;
        $display("FAIL bubble: got tvalid=0 inside packet want 1");
      end

      if (o_tvalid && o_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected word: got %h want none", {o_tlast, o_tdata});
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== e) begin
            n_err++;
            $display("FAIL word[%0d]: got tlast=%0b data=%h want tlast=%0b data=%h",
                     word_no, o_tlast, o_tdata, e[64], e[63:0]);
          end
        end
        word_no++;
        in_pkt = !o_tlast;
        if (o_tlast) begin
          gap_arm = 1'b1; idle_cnt = 0;
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int total, consumed;
    logic [31:0] s;

    #2;
    check("reset tvalid", 64'(o_tvalid), 64'd0);
    check("reset tdata", o_tdata, 64'd0);
    check("reset running/done", {62'd0, running, done}, 64'd0);
    check("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    #20 bus_rst_n = 1'b1;

    // fixed seed pattern, back-to-back packets with the ready held high
    chk_gap = 1'b1; exp_gap = 0;
    run_counted("basic", 1'b0, 40, 10, 0, 32'h01234567);
    check("basic done", 64'(done), 64'd1);

    // gap behaviour: short length rounds up to one payload word
    exp_gap = 4;
    run_counted("gap1", 1'b0, 5, 1, 4, $urandom);
    run_counted("gap2", 1'b1, 5, 2, 4, $urandom);
    chk_gap = 1'b0;

    // backpressure with ramp payload and length boundaries
    rdy_rand = 1'b1;
    run_counted("ramp_bp", 1'b1, 40, 3, 0, $urandom);
    run_counted("len0", 1'b1, 0, 1, 1, $urandom);
    run_counted("len8", 1'b0, 8, 2, 0, $urandom);
    run_counted("len9", 1'b1, 9, 2, 2, $urandom);
    for (int i = 0; i < 4; i++)
      run_counted("random", 1'($urandom_range(0, 1)), $urandom_range(0, 80),
                  $urandom_range(1, 4), $urandom_range(0, 3), $urandom);
    rdy_rand = 1'b0;

    // zero packets: finish immediately without any words
    configure(1'b0, 40, 0, 0, $urandom);
    sr_write(8'd0, 32'h1);
    wait_done(2, "num0");
    check("num0 pkt_cnt", 64'(pkt_cnt), 64'd0);

    // continuous run stopped mid-stream
    s = $urandom;
    configure(1'b0, 256, 1, 0, s);
    push_packets(1'b0, 256, 40, s);
    total = exp_q.size();
    sr_write(8'd0, 32'h3);
    #2000;
    sr_write(8'd0, 32'h0);
    wait_done(3000, "stop");
    consumed = total - exp_q.size();
    check("stop whole packets", 64'(consumed % 33), 64'd0);
    check("stop pkt_cnt", 64'(pkt_cnt), 64'(consumed / 33));
    check("stop pkt_cnt nonzero", 64'(pkt_cnt != 0), 64'd1);
    check("stop running", 64'(running), 64'd0);
    exp_q.delete();
    sr_write(8'd0, 32'h0);
    check("done cleared", 64'(done), 64'd0);

    // go while running is ignored
    s = $urandom;
    configure(1'b1, 24, 3, 1, s);
    push_packets(1'b1, 24, 3, s);
    sr_write(8'd0, 32'h1);
    repeat (3) @(posedge bus_clk);
    sr_write(8'd0, 32'h1);
    wait_done(200, "rego");
    check("rego pkt_cnt", 64'(pkt_cnt), 64'd3);
    check("rego leftover", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // reset during payload
    s = $urandom;
    configure(1'b1, 256, 2, 0, s);
    push_packets(1'b1, 256, 2, s);
    total = exp_q.size();
    sr_write(8'd0, 32'h1);
    for (int c = 0; c < 200 && exp_q.size() > total - 5; c++) @(posedge bus_clk);
    #3 bus_rst_n = 1'b0;
    #1;
    check("rst tvalid", 64'(o_tvalid), 64'd0);
    check("rst tdata", o_tdata, 64'd0);
    check("rst tlast/running/done", {61'd0, o_tlast, running, done}, 64'd0);
    check("rst pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge bus_clk); #3 bus_rst_n = 1'b1;
    exp_q.delete();
    repeat (40) @(posedge bus_clk);
    // config registers cleared by reset: go alone means zero packets
    sr_write(8'd0, 32'h1);
    wait_done(2, "post-reset go");
    check("post-reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    repeat (5) @(posedge bus_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_fifo_bist_gen.md
DRAM_FIFO_BIST_GEN -- requirements
Module: dram_fifo_bist_gen

Interface
REQ-001 Parameter SR_BASE, default 0, settings-bus base address of the four config registers.
REQ-002 Parameter SR_AWIDTH, default 8, settings-bus address width.
REQ-003 bus_clk  in  1  sole clock; all logic on rising edge.
REQ-004 bus_rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-005 set_stb  in  1  settings write strobe.
REQ-006 set_addr  in  SR_AWIDTH  settings address.
REQ-007 set_data  in  32  settings data.
REQ-008 o_tdata  out  64  generated CVITA word.
REQ-009 o_tlast  out  1  last word of packet.
REQ-010 o_tvalid  out  1  word valid.
REQ-011 o_tready  in  1  downstream (AXI MUX to DRAM FIFO) ready.
REQ-012 running  out  1  generator active.
REQ-013 done  out  1  run finished.
REQ-014 pkt_cnt  out  32  packets fully sent since last start.

Function
REQ-015 The block SHALL decode registers: SR_BASE+0 CTRL {..,cont[1],go[0]}; +1 CFG {ramp[31],len_bytes[30:18],num_pkts[17:0]}; +2 GAP {gap_cycles[7:0]}; +3 SEED[31:0]; other addresses ignored.
REQ-016 The block SHALL capture CFG, GAP, SEED on any write; values in use SHALL be latched at start and not change mid-run.
REQ-017 States SHALL be IDLE, HDR, PAYLOAD, GAP, FINISH.
REQ-018 IDLE->HDR SHALL occur the cycle after a CTRL write with go=1 while IDLE or FINISH; pkt_cnt SHALL clear and done SHALL drop at that transition.
REQ-019 A CTRL write with go=0 SHALL clear done and set a stop request.
REQ-020 Payload word count W SHALL be ceil(len_bytes/8), with len_bytes<8 treated as W=1.
REQ-021 HDR word SHALL be {4'b0000, seqnum[11:0]=pkt_cnt[11:0], length[15:0]=8*W+8, sid[31:0]=SEED}, tlast=0.
REQ-022 PAYLOAD word k (0..W-1) SHALL be {SEED, ~SEED} when ramp=0, {pkt_cnt[31:0], k[31:0]} when ramp=1; tlast=1 only on k=W-1.
REQ-023 A word SHALL advance only on o_tvalid&o_tready; o_tdata/o_tlast SHALL be stable while o_tvalid&~o_tready.
REQ-024 o_tvalid SHALL be 1 in HDR and PAYLOAD and 0 otherwise; no bubbles within a packet when o_tready is held high (one word per cycle).
REQ-025 On the tlast handshake pkt_cnt SHALL increment; next state SHALL be FINISH if stop requested or (cont=0 and pkt_cnt+1==num_pkts), else GAP if gap_cycles>0, else HDR directly.
REQ-026 GAP SHALL hold o_tvalid=0 for exactly gap_cycles cycles then go to HDR (or FINISH if stop requested meanwhile).
REQ-027 Stop request SHALL never truncate a packet; the current packet SHALL complete with tlast.
REQ-028 num_pkts=0 with cont=0 SHALL go HDR-free to FINISH one cycle after start; no words emitted.
REQ-029 cont=1 SHALL ignore num_pkts; pkt_cnt SHALL wrap 0xFFFFFFFF->0.
REQ-030 FINISH SHALL assert done=1, running=0 and hold until next CTRL write.
REQ-031 running SHALL be 1 in HDR, PAYLOAD, GAP.
REQ-032 go=1 written while running SHALL be ignored.

Reset
REQ-033 bus_rst_n=0 SHALL immediately force state IDLE, o_tvalid=0, o_tlast=0, o_tdata=0, running=0, done=0, pkt_cnt=0, all config registers 0, stop request cleared.
REQ-034 Reset mid-packet SHALL abandon the packet; after release no words emitted until a new go write.

Verification
REQ-035 len=40, num=10, ramp=0, seed=0x01234567, gap=0, tready=1 -> 10 packets of 6 words, header length 48, seqnum 0..9, payload 0x01234567FEDCBA98, done=1, pkt_cnt=10.
REQ-036 len=40, num=3, ramp=1, tready toggling randomly -> payload word k of packet p = {p,k}, data stable under backpressure, 3 tlasts.
REQ-037 len=5, num=1, gap=4 -> 2 words, header length 16; num=2 -> exactly 4 idle cycles between packets.
REQ-038 cont=1, len=256, go=0 written mid-packet after ~2000 ns -> packet completes with tlast, then done=1, running=0, pkt_cnt>0.
REQ-039 num=0, cont=0 -> done=1 within 2 cycles, o_tvalid never asserted.
REQ-040 bus_rst_n pulsed low during PAYLOAD -> outputs zero immediately, no further output until new config and go.
